// File: rtl/spi_peri_rx.sv
// spi_peri_rx
//   SPI peripheral-side receiver for the MOSI direction, mode 0, MSB first.
//   The asynchronous SPI pins are oversampled in the clk domain. Bytes are
//   deframed and handed to the consumer on a valid/ready stream through a
//   small FIFO.
//
// Parameters
//   SYNC_STAGES  synchronizer depth on sck/csn/mosi (>= 2)
//   FIFO_DEPTH   receive FIFO entries (power of two, >= 2)
//
// Ports
//   clk        system clock, sole clock of the block
//   rst_n      asynchronous active-low reset
//   spi_sck    SPI clock (async to clk)
//   spi_csn    SPI chip select, active-low (async to clk)
//   spi_mosi   SPI data from controller (async to clk)
//   rx_data    head-of-FIFO byte, meaningful while rx_valid=1
//   rx_valid   FIFO not empty
//   rx_ready   consumer accepts rx_data when rx_valid & rx_ready
//   overflow   sticky: a completed byte was dropped on a full FIFO
//   ovf_clr    clears overflow (a new overflow wins over the clear)
//   frame_err  1-cycle pulse: csn released mid-byte
//   busy       synchronized csn is low
module spi_peri_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       overflow,
    input  logic       ovf_clr,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned SW = $clog2(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '1;
            csn_sync  <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    logic sck_s;
    logic csn_s;
    logic mosi_s;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign csn_s  = csn_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Start-up gating: the synchronizers come out of reset holding csn=1,
    // which is not a real observation of the pin. Only once the reset
    // values have been flushed out do we look for a genuine idle csn, so a
    // frame cut by reset is ignored until the controller ends it.
    // ------------------------------------------------------------------
    logic [SW-1:0] settle_cnt;
    logic          settled;
    logic          armed;

    assign settled = (settle_cnt == SW'(SYNC_STAGES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            if (!settled) begin
                settle_cnt <= settle_cnt + SW'(1);
            end
            if (settled && csn_s) begin
                armed <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic sck_q;
    logic csn_q;
    logic sck_rise;
    logic csn_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 1'b1;
            csn_q <= 1'b1;
        end else begin
            sck_q <= sck_s;
            csn_q <= csn_s;
        end
    end

    // csn_s=1 on a csn rise, so a coincident sck rise is dropped here too
    assign csn_rise = csn_s & ~csn_q;
    assign sck_rise = sck_s & ~sck_q & ~csn_s & armed;

    // ------------------------------------------------------------------
    // Deframer
    // ------------------------------------------------------------------
    logic [7:0] shifter;
    logic [2:0] bit_cnt;
    logic [7:0] byte_q;
    logic       byte_vld_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shifter    <= '0;
            bit_cnt    <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            frame_err  <= 1'b0;
            if (csn_rise) begin
                shifter   <= '0;
                bit_cnt   <= '0;
                frame_err <= (bit_cnt != 3'd0);
            end else if (sck_rise) begin
                shifter <= {shifter[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_q     <= {shifter[6:0], mosi_s};
                    byte_vld_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO: pointers carry one extra wrap bit
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = rx_valid & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push  = byte_vld_q & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= byte_q;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (byte_vld_q && full && !pop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign rx_valid = ~empty;
    assign rx_data  = mem[rd_ptr[AW-1:0]];
    assign busy     = ~csn_s;

endmodule

// File: tb/tb_spi_peri_rx.sv
module tb_spi_peri_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       spi_sck = 1'b0;
    logic       spi_csn = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overflow;
    logic       ovf_clr = 1'b0;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    spi_peri_rx #(
        .SYNC_STAGES(2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sck  (spi_sck),
        .spi_csn  (spi_csn),
        .spi_mosi (spi_mosi),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Record accepted bytes and frame_err cycles midway between clk edges
    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) fe_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL timeout: observed no finish, required finish before 400us");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_got(input string tag);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), (i < got.size()) ? {24'h0, got[i]} : 32'hxxxx_xxxx,
                {24'h0, exp_q[i]});
        end
        got.delete();
    endtask

    // Sends the n most significant bits of b, SPI mode 0, sck = clk/8
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            repeat (4) tick();
            spi_sck = 1'b1;
            repeat (4) tick();
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 8);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (8) tick();
        chk("idle_busy", busy, 0);

        // 1: single byte 0xA5, latency 4 clk from the 8th sck rise
        rx_ready = 1'b1;
        spi_csn  = 1'b0;
        repeat (6) tick();
        chk("t1_busy", busy, 1);
        send_bits(8'hA5, 7);
        spi_mosi = 1'b1;
        repeat (4) tick();
        spi_sck = 1'b1;
        repeat (3) tick();
        chk("t1_valid_at3", rx_valid, 0);
        tick();
        chk("t1_valid_at4", rx_valid, 1);
        chk("t1_data", rx_data, 8'hA5);
        tick();
        chk("t1_pulse_end", rx_valid, 0);
        spi_sck = 1'b0;
        repeat (4) tick();
        exp_q = '{8'hA5};
        check_got("t1_bytes");

        // 2: back-to-back bytes in the same frame
        send_byte(8'h01);
        send_byte(8'h80);
        send_byte(8'hFF);
        send_byte(8'h00);
        repeat (8) tick();
        exp_q = '{8'h01, 8'h80, 8'hFF, 8'h00};
        check_got("t2_bytes");
        chk("t2_overflow", overflow, 0);
        spi_csn = 1'b1;
        repeat (6) tick();
        chk("t2_frame_err_cnt", fe_cnt, 0);
        chk("t2_busy", busy, 0);

        // 3: overflow with consumer stalled, then drain and clear
        rx_ready = 1'b0;
        spi_csn  = 1'b0;
        repeat (6) tick();
        for (int b = 8'h10; b <= 8'h14; b++) send_byte(8'(b));
        repeat (8) tick();
        chk("t3_overflow_set", overflow, 1);
        chk("t3_valid", rx_valid, 1);
        chk("t3_head", rx_data, 8'h10);
        spi_csn  = 1'b1;
        rx_ready = 1'b1;
        repeat (8) tick();
        exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
        check_got("t3_drain");
        chk("t3_empty", rx_valid, 0);
        chk("t3_overflow_sticky", overflow, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_overflow_clr", overflow, 0);

        // 4: partial byte then csn release, followed by a clean frame
        spi_csn = 1'b0;
        repeat (6) tick();
        send_bits(8'hA0, 3);
        repeat (4) tick();
        spi_csn = 1'b1;
        repeat (8) tick();
        chk("t4_frame_err_cnt", fe_cnt, 1);
        exp_q.delete();
        check_got("t4_no_bytes");
        spi_csn = 1'b0;
        repeat (6) tick();
        send_byte(8'h3C);
        repeat (8) tick();
        spi_csn = 1'b1;
        repeat (6) tick();
        exp_q = '{8'h3C};
        check_got("t4_next");
        chk("t4_frame_err_cnt2", fe_cnt, 1);

        // 5: push into a full FIFO while a pop happens in the same clk
        rx_ready = 1'b0;
        spi_csn  = 1'b0;
        repeat (6) tick();
        send_byte(8'h20);
        send_byte(8'h21);
        send_byte(8'h22);
        send_byte(8'h23);
        send_bits(8'h24, 7);
        spi_mosi = 1'b0;
        repeat (4) tick();
        spi_sck = 1'b1;
        repeat (3) tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("t5_overflow", overflow, 0);
        chk("t5_valid", rx_valid, 1);
        chk("t5_head", rx_data, 8'h21);
        exp_q = '{8'h20};
        check_got("t5_popped");
        spi_sck = 1'b0;
        repeat (4) tick();
        spi_csn  = 1'b1;
        rx_ready = 1'b1;
        repeat (8) tick();
        exp_q = '{8'h21, 8'h22, 8'h23, 8'h24};
        check_got("t5_drain");
        chk("t5_empty", rx_valid, 0);
        chk("t5_overflow_end", overflow, 0);

        // 6: reset in the middle of a frame
        rx_ready = 1'b0;
        spi_csn  = 1'b0;
        repeat (6) tick();
        send_byte(8'h77);
        send_bits(8'hF0, 4);
        chk("t6_pre_valid", rx_valid, 1);
        chk("t6_pre_data", rx_data, 8'h77);
        chk("t6_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_data", rx_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_frame_err", frame_err, 0);
        repeat (3) tick();
        rst_n    = 1'b1;
        rx_ready = 1'b1;
        send_bits(8'hA0, 4);
        repeat (4) tick();
        spi_csn = 1'b1;
        repeat (8) tick();
        chk("t6_no_frame_err", fe_cnt, 1);
        spi_csn = 1'b0;
        repeat (6) tick();
        send_byte(8'h5A);
        repeat (8) tick();
        spi_csn = 1'b1;
        repeat (6) tick();
        exp_q = '{8'h5A};
        check_got("t6_bytes");
        chk("t6_overflow", overflow, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
